storage_write_arbiter: RTL
==========================

Name: storage_write_arbiter

Overview:
- Shares one 4-bit storage register (a `set`-strobed capture register) among N_REQ requesters.
- Picks one requester round-robin and latches its data.
- Drives the register's data input, then fires a single-cycle `set` strobe and acks the winner.
- Sits between requester logic (counters, dividers, test sources) and the shared storage element. It is the only agent allowed to drive that register.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 4, data width of the storage register.
- SETUP_CYCLES, 1, cycles `origin` is held stable before `set` rises (1..7).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester write request; level, held until ack.
- req_data  input  N_REQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- ack  output  N_REQ  one-cycle pulse to the requester whose write completed.
- origin  output  WIDTH  data driven to the storage register input.
- set  output  1  storage capture strobe, high for exactly one cycle per write.
- busy  output  1  high in every state except IDLE.
- grant_id  output  $clog2(N_REQ)  index of the current or last granted requester.
- wr_count  output  8  number of completed writes; wraps 255 -> 0.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst). Sampled only at the rising edge of clk.
- Reset values:
  - state=IDLE; ack=0, origin=0, set=0, busy=0, grant_id=0, wr_count=0.
  - RR pointer=0; setup counter=0.
- States: IDLE -> SETUP -> STROBE -> ACK -> IDLE.
- IDLE:
  - If req != 0, select the winner. The winner is the first asserted bit scanning from the pointer upward, wrapping at N_REQ-1 -> 0.
  - On the same edge, latch grant_id and the winner's req_data slice into origin. Load the setup counter with SETUP_CYCLES and go to SETUP.
  - If req == 0, stay in IDLE; origin holds its last value.
- SETUP:
  - set=0; origin stable.
  - Decrement the counter; when it reaches 0, go to STROBE.
  - Dwell is exactly SETUP_CYCLES cycles.
- STROBE:
  - set=1 for exactly one cycle; origin unchanged. Next state is ACK.
- ACK:
  - ack[grant_id]=1 for one cycle; set=0.
  - wr_count increments by 1 (mod 256).
  - Pointer becomes (grant_id+1) mod N_REQ. Next state is IDLE.
- Latency from req seen in IDLE to set high: SETUP_CYCLES+1 cycles. To ack: SETUP_CYCLES+2 cycles.
- Back-to-back writes: minimum spacing between set pulses is SETUP_CYCLES+3 cycles.
- Data is latched at grant. req_data changes after grant do not affect origin.
- req deasserted after grant: the transaction still completes, and set and ack are still issued.
- Requests that rise during SETUP, STROBE or ACK wait; they are arbitrated at the next IDLE.
- A requester must drop req on the cycle after ack, or it is eligible again. Round-robin prevents starvation. Worst-case wait is (N_REQ-1) full transactions.
- rst during any state returns to IDLE next edge with all reset values. Specifically:
  - set and ack are forced low.
  - An aborted write produces no strobe, no ack and no wr_count increment.
- Only one ack bit and at most one set pulse are ever active at a time.

Optional Feature:
- Macro: STORAGE_ARB_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority (lowest index wins). The pointer is removed and never updates, so requester 0 can starve others.
- Undefined (default): round-robin as above.
- All other timing is identical in both modes.

Test Plan:
- Single request: rst 2 cycles, then req=0001 with slice0=1010, SETUP_CYCLES=1.
  - set high exactly 2 cycles after req is seen; origin=1010 during SETUP and STROBE.
  - ack=0001 next cycle; wr_count=1.
- Round-robin: req=1111 held with ack-driven drops and re-raises.
  - grant_id sequence is 0,1,2,3,0.
  - set pulses spaced 4 cycles apart; wr_count=5 after 5 acks.
- Data latch: grant requester 2 with slice2=0101, then change slice2 to 1111 during SETUP.
  - origin stays 0101 through STROBE.
- Reset mid-op: assert rst in SETUP.
  - Next cycle: state IDLE, set=0, ack=0, wr_count unchanged (0).
  - No strobe occurs.
- Wrap and request drop:
  - 256 completed writes -> wr_count=0.
  - Requester drops req during SETUP -> set and ack still pulse once.
- With STORAGE_ARB_FIXED_PRIO_EN: req=0101 held continuously -> grant_id=0 on every transaction; requester 2 is never acked.

Source files
------------

// File: rtl/storage_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// storage_write_arbiter_if
// Bundles the requester-facing and storage-facing signals of the shared
// storage write arbiter.
//   req       : per-requester write request (level, held until ack)
//   req_data  : packed requester data, requester i at [i*WIDTH +: WIDTH]
//   ack       : one-cycle completion pulse to the winning requester
//   origin    : data presented to the storage register input
//   set       : one-cycle storage capture strobe
//   busy      : arbiter is mid-transaction
//   grant_id  : index of the current or last granted requester
//   wr_count  : completed write count, wraps at 256
// Modports: master = requester/storage side, slave = arbiter.
// -----------------------------------------------------------------------------
interface storage_write_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH-1:0]       origin;
    logic                   set;
    logic                   busy;
    logic [GW-1:0]          grant_id;
    logic [7:0]             wr_count;

    modport master (
        output req, req_data,
        input  ack, origin, set, busy, grant_id, wr_count
    );

    modport slave (
        input  req, req_data,
        output ack, origin, set, busy, grant_id, wr_count
    );
endinterface

// File: rtl/storage_write_arbiter.sv
// -----------------------------------------------------------------------------
// storage_write_arbiter
// Shares one set-strobed storage register among N_REQ requesters. A winner is
// picked in IDLE, its data latched onto origin, held for SETUP_CYCLES, then a
// single-cycle set strobe is fired, followed by a single-cycle ack.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : storage_write_arbiter_if.slave (req, req_data in; ack, origin,
//         set, busy, grant_id, wr_count out)
// Build option:
//   STORAGE_ARB_FIXED_PRIO_EN : lowest index always wins (no RR pointer).
//   Undefined (default)       : round-robin starting after the last winner.
// -----------------------------------------------------------------------------
module storage_write_arbiter #(
    parameter int N_REQ        = 4,
    parameter int WIDTH        = 4,
    parameter int SETUP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    storage_write_arbiter_if.slave bus
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [GW-1:0]    grant_q, grant_next;
    logic [WIDTH-1:0] origin_q, origin_next;
    logic [2:0]       cnt_q, cnt_next;
    logic [7:0]       wr_q, wr_next;
    logic [GW-1:0]    win_id;
    logic             win_vld;
`ifndef STORAGE_ARB_FIXED_PRIO_EN
    logic [GW-1:0]    ptr_q, ptr_next;
`endif

    // Winner search: first asserted request scanning upward from the start
    // index, wrapping past N_REQ-1 back to 0.
    always_comb begin
        int idx;
        idx     = 0;
        win_id  = '0;
        win_vld = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
`ifdef STORAGE_ARB_FIXED_PRIO_EN
            idx = i;
`else
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
`endif
            if (!win_vld && bus.req[idx]) begin
                win_vld = 1'b1;
                win_id  = GW'(idx);
            end
        end
    end

    always_comb begin
        state_next  = state;
        grant_next  = grant_q;
        origin_next = origin_q;
        cnt_next    = cnt_q;
        wr_next     = wr_q;
`ifndef STORAGE_ARB_FIXED_PRIO_EN
        ptr_next    = ptr_q;
`endif
        case (state)
            IDLE: begin
                if (win_vld) begin
                    grant_next  = win_id;
                    origin_next = bus.req_data[int'(win_id)*WIDTH +: WIDTH];
                    cnt_next    = 3'(SETUP_CYCLES);
                    state_next  = SETUP;
                end
            end
            SETUP: begin
                // Dwell ends on the cycle the counter would reach zero.
                cnt_next = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_next = STROBE;
            end
            STROBE: begin
                // Count the write as the strobe completes so it is visible with ack.
                wr_next    = wr_q + 8'd1;
                state_next = ACK;
            end
            ACK: begin
`ifndef STORAGE_ARB_FIXED_PRIO_EN
                ptr_next = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + GW'(1);
`endif
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_q  <= '0;
            origin_q <= '0;
            cnt_q    <= '0;
            wr_q     <= '0;
`ifndef STORAGE_ARB_FIXED_PRIO_EN
            ptr_q    <= '0;
`endif
        end else begin
            state    <= state_next;
            grant_q  <= grant_next;
            origin_q <= origin_next;
            cnt_q    <= cnt_next;
            wr_q     <= wr_next;
`ifndef STORAGE_ARB_FIXED_PRIO_EN
            ptr_q    <= ptr_next;
`endif
        end
    end

    // Strobe and ack decode straight from the state register, so reset
    // forces both low on the same edge that returns the FSM to IDLE.
    assign bus.set      = (state == STROBE);
    assign bus.ack      = (state == ACK) ? (N_REQ'(1) << grant_q) : '0;
    assign bus.busy     = (state != IDLE);
    assign bus.origin   = origin_q;
    assign bus.grant_id = grant_q;
    assign bus.wr_count = wr_q;
endmodule
